// File: rtl/lsu_mem_align_pkg.sv
// rtl/lsu_mem_align_pkg.sv - shared funct3 constants, FSM states and lane helpers
// Purpose: common definitions for the LSU alignment stage.
// Contents: F3_* load/store size codes, lsu_st_e FSM states,
//           f3_legal() legality check, lane_mask() two-word byte-lane mask.
package lsu_mem_align_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, SPLIT} lsu_st_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Lanes touched across the addressed word [3:0] and the next word [7:4].
  // Any bit set in [7:4] means the access has to be split into two beats.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_mem_align_if.sv
// rtl/lsu_mem_align_if.sv - LSU request/response and SRAM port bundle
// Purpose: groups the LSU request/response and SRAM signals of the alignment stage.
// Modports: master = LSU + SRAM side (drives req_*, mem_rd),
//           slave  = alignment stage (drives req_rdy, rsp_*, mem_a/we/wd/re).
interface lsu_mem_align_if #(parameter int AW = 16);

  logic          req_vld;
  logic          req_rdy;
  logic          req_we;
  logic [2:0]    req_f3;
  logic [AW-1:0] req_a;
  logic [31:0]   req_wd;

  logic          rsp_vld;
  logic [31:0]   rsp_rd;
  logic          rsp_err;

  logic [AW-1:0] mem_a;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wd;
  logic [3:0]    mem_re;
  logic [31:0]   mem_rd;

  modport master (
    output req_vld, req_we, req_f3, req_a, req_wd, mem_rd,
    input  req_rdy, rsp_vld, rsp_rd, rsp_err, mem_a, mem_we, mem_wd, mem_re
  );

  modport slave (
    input  req_vld, req_we, req_f3, req_a, req_wd, mem_rd,
    output req_rdy, rsp_vld, rsp_rd, rsp_err, mem_a, mem_we, mem_wd, mem_re
  );

endinterface

// File: rtl/lsu_mem_align_ld_ext.sv
// rtl/lsu_mem_align_ld_ext.sv - load byte extract and sign/zero extension
// Purpose: selects the addressed bytes of a 32-bit word and extends them per funct3.
// Ports: word (in 32) source word, off (in 2) starting byte lane,
//        f3 (in 3) load funct3, data (out 32) extended result (0 for illegal f3).
module lsu_ld_ext
  import lsu_mem_align_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    sh   = word >> {off, 3'b000};
    data = '0;
    case (f3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_W:    data = sh;
      F3_BU:   data = {24'b0, sh[7:0]};
      F3_HU:   data = {16'b0, sh[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_align.sv
// rtl/lsu_mem_align.sv - LSU load/store alignment stage in front of a byte-lane SRAM
// Purpose: converts byte address + funct3 into SRAM word accesses with byte lanes,
//          splits word-crossing accesses into two beats and aligns/extends load data.
// Ports: clk, rstn (async active-low); bus (slave modport) carrying
//        req_vld/req_rdy/req_we/req_f3/req_a/req_wd, rsp_vld/rsp_rd/rsp_err,
//        mem_a/mem_we/mem_wd/mem_re/mem_rd.
module lsu_mem_align
  import lsu_mem_align_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  lsu_mem_align_if.slave  bus
);

  lsu_st_e         state_q, state_d;

  // Second-beat context of a split access.
  logic [AW-3:0]   sp_wa_q, sp_wa_d;
  logic [3:0]      sp_en_q, sp_en_d;
  logic [31:0]     sp_wd_q, sp_wd_d;
  logic            sp_we_q, sp_we_d;
  logic [2:0]      sp_f3_q, sp_f3_d;
  logic [1:0]      sp_off_q, sp_off_d;

  // Load response pipeline: one stage, aligned with SRAM read latency.
  logic            ld_vld_q, ld_vld_d;
  logic            ld_err_q, ld_err_d;
  logic            ld_ill_q, ld_ill_d;
  logic            ld_split_q, ld_split_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic [31:0]     hold_q, hold_d;

  logic            req_rdy;
  logic            fire;
  logic            legal;
  logic            split;
  logic [7:0]      mask;
  logic [63:0]     wd_sh;
  logic [AW-1:0]   mem_a_c;
  logic [3:0]      mem_we_c;
  logic [3:0]      mem_re_c;
  logic [31:0]     mem_wd_c;
  logic [31:0]     merged;
  logic [31:0]     ext_word;
  logic [1:0]      ext_off;
  logic [31:0]     ext_data;

  always_comb begin
    req_rdy    = (state_q == IDLE);
    fire       = bus.req_vld & req_rdy;
    legal      = f3_legal(bus.req_f3);
    mask       = lane_mask(bus.req_f3, bus.req_a[1:0]);
    split      = legal & (|mask[7:4]);
    wd_sh      = {32'b0, bus.req_wd} << {bus.req_a[1:0], 3'b000};

    state_d    = state_q;
    sp_wa_d    = sp_wa_q;
    sp_en_d    = sp_en_q;
    sp_wd_d    = sp_wd_q;
    sp_we_d    = sp_we_q;
    sp_f3_d    = sp_f3_q;
    sp_off_d   = sp_off_q;
    ld_vld_d   = 1'b0;
    ld_err_d   = 1'b0;
    ld_ill_d   = 1'b0;
    ld_split_d = 1'b0;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    hold_d     = hold_q;
    mem_a_c    = '0;
    mem_we_c   = 4'b0;
    mem_re_c   = 4'b0;
    mem_wd_c   = '0;

    case (state_q)
      IDLE: begin
        // Same-cycle issue: the SRAM sees the request straight through.
        mem_a_c  = {bus.req_a[AW-1:2], 2'b00};
        mem_wd_c = wd_sh[31:0];
        if (bus.req_vld && legal) begin
          if (bus.req_we) mem_we_c = mask[3:0];
          else            mem_re_c = mask[3:0];
        end
        if (fire) begin
          if (!legal) begin
            ld_err_d = 1'b1;
            ld_ill_d = 1'b1;
            ld_vld_d = ~bus.req_we;
          end else if (split) begin
            state_d  = SPLIT;
            sp_wa_d  = bus.req_a[AW-1:2] + 1'b1;
            sp_en_d  = mask[7:4];
            sp_wd_d  = wd_sh[63:32];
            sp_we_d  = bus.req_we;
            sp_f3_d  = bus.req_f3;
            sp_off_d = bus.req_a[1:0];
          end else begin
            ld_vld_d = ~bus.req_we;
            ld_f3_d  = bus.req_f3;
            ld_off_d = bus.req_a[1:0];
          end
        end
      end
      SPLIT: begin
        mem_a_c  = {sp_wa_q, 2'b00};
        mem_wd_c = sp_wd_q;
        if (sp_we_q) mem_we_c = sp_en_q;
        else         mem_re_c = sp_en_q;
        state_d  = IDLE;
        if (!sp_we_q) begin
          // mem_rd currently carries the beat-1 word; park it for the merge.
          hold_d     = bus.mem_rd;
          ld_vld_d   = 1'b1;
          ld_split_d = 1'b1;
          ld_f3_d    = sp_f3_q;
          ld_off_d   = sp_off_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sp_wa_q    <= '0;
      sp_en_q    <= 4'b0;
      sp_wd_q    <= '0;
      sp_we_q    <= 1'b0;
      sp_f3_q    <= 3'b0;
      sp_off_q   <= 2'b0;
      ld_vld_q   <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_ill_q   <= 1'b0;
      ld_split_q <= 1'b0;
      ld_f3_q    <= 3'b0;
      ld_off_q   <= 2'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      sp_wa_q    <= sp_wa_d;
      sp_en_q    <= sp_en_d;
      sp_wd_q    <= sp_wd_d;
      sp_we_q    <= sp_we_d;
      sp_f3_q    <= sp_f3_d;
      sp_off_q   <= sp_off_d;
      ld_vld_q   <= ld_vld_d;
      ld_err_q   <= ld_err_d;
      ld_ill_q   <= ld_ill_d;
      ld_split_q <= ld_split_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      hold_q     <= hold_d;
    end
  end

  // Split loads: beat-1 upper bytes (from hold_q) form the low end, beat-2
  // bytes from mem_rd fill in above; the result is then extracted at lane 0.
  always_comb begin
    case (ld_off_q)
      2'd1:    merged = {bus.mem_rd[7:0],  hold_q[31:8]};
      2'd2:    merged = {bus.mem_rd[15:0], hold_q[31:16]};
      2'd3:    merged = {bus.mem_rd[23:0], hold_q[31:24]};
      default: merged = hold_q;
    endcase
    ext_word = ld_split_q ? merged : bus.mem_rd;
    ext_off  = ld_split_q ? 2'b00  : ld_off_q;
  end

  lsu_ld_ext u_ld_ext (
    .word (ext_word),
    .off  (ext_off),
    .f3   (ld_f3_q),
    .data (ext_data)
  );

  // Combinational SRAM outputs are gated so reset takes effect immediately.
  assign bus.req_rdy = req_rdy;
  assign bus.mem_a   = rstn ? mem_a_c  : '0;
  assign bus.mem_we  = rstn ? mem_we_c : 4'b0;
  assign bus.mem_re  = rstn ? mem_re_c : 4'b0;
  assign bus.mem_wd  = rstn ? mem_wd_c : '0;
  assign bus.rsp_vld = ld_vld_q;
  assign bus.rsp_err = ld_err_q;
  assign bus.rsp_rd  = (ld_vld_q && !ld_ill_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_mem_align.sv
// tb/tb_lsu_mem_align.sv - self-checking bench for lsu_mem_align
module tb_lsu_mem_align;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  logic [31:0] sram    [0:16383];
  logic [7:0]  ref_mem [0:65535];

  lsu_mem_align_if #(.AW(16)) bus ();

  lsu_mem_align #(.AW(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with one-cycle read latency and byte-lane writes.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (bus.mem_we[l]) sram[bus.mem_a[15:2]][8*l +: 8] <= bus.mem_wd[8*l +: 8];
    if (|bus.mem_re) bus.mem_rd <= sram[bus.mem_a[15:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    sram[a[15:2]] = d;
    for (int i = 0; i < 4; i++) ref_mem[{a[15:2], 2'b00} + 16'(i)] = d[8*i +: 8];
  endtask

  function automatic int sz(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference load: gather n bytes little-endian with 16-bit address wrap.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [15:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < sz(f3); i++) v[8*i +: 8] = ref_mem[16'(a + 16'(i))];
    case (f3)
      3'b000:  v = {{24{v[7]}}, v[7:0]};
      3'b001:  v = {{16{v[15]}}, v[15:0]};
      3'b010, 3'b100, 3'b101: v = v;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic acc(input logic we, input logic [2:0] f3, input logic [15:0] a,
                     input logic [31:0] wd);
    int n, off;
    bit legal, split;
    logic [31:0] exp_rd, ewd;
    logic [3:0] en;
    logic [15:0] wa;
    n      = sz(f3);
    legal  = (n != 0);
    off    = int'(a[1:0]);
    split  = legal && (off + n > 4);
    exp_rd = ref_load(f3, a);

    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_we = we; bus.req_f3 = f3; bus.req_a = a; bus.req_wd = wd;
    #1;
    en = '0; ewd = '0;
    for (int l = 0; l < 4; l++) begin
      if (legal && l >= off && l < off + n) en[l] = 1'b1;
      if (l >= off) ewd[8*l +: 8] = wd[8*(l-off) +: 8];
    end
    chk("beat1_rdy", bus.req_rdy, 1);
    chk("beat1_rsp_vld", bus.rsp_vld, 0);
    chk("beat1_mem_a", bus.mem_a, {a[15:2], 2'b00});
    chk("beat1_mem_we", bus.mem_we, we ? en : 4'b0);
    chk("beat1_mem_re", bus.mem_re, we ? 4'b0 : en);
    if (we && legal) chk("beat1_mem_wd", bus.mem_wd, ewd);

    if (split) begin
      @(negedge clk); #1;
      wa = {a[15:2], 2'b00} + 16'd4;
      en = '0; ewd = '0;
      for (int l = 0; l < 4; l++) begin
        if (l + 4 < off + n) en[l] = 1'b1;
        if (l + 4 - off < 4) ewd[8*l +: 8] = wd[8*(l+4-off) +: 8];
      end
      chk("beat2_rdy", bus.req_rdy, 0);
      chk("beat2_rsp_vld", bus.rsp_vld, 0);
      chk("beat2_mem_a", bus.mem_a, wa);
      chk("beat2_mem_we", bus.mem_we, we ? en : 4'b0);
      chk("beat2_mem_re", bus.mem_re, we ? 4'b0 : en);
      if (we) chk("beat2_mem_wd", bus.mem_wd, ewd);
    end

    @(negedge clk);
    bus.req_vld = 1'b0;
    #1;
    chk("rsp_vld", bus.rsp_vld, {31'b0, !we});
    chk("rsp_err", bus.rsp_err, {31'b0, !legal});
    if (!we) chk("rsp_rd", bus.rsp_rd, legal ? exp_rd : 32'h0);
    if (we && legal)
      for (int i = 0; i < n; i++) ref_mem[16'(a + 16'(i))] = wd[8*i +: 8];
  endtask

  initial begin
    logic [31:0] q [$];
    logic [31:0] v;
    logic [15:0] a;
    logic [2:0]  f3;
    logic        we;

    checks = 0;
    errors = 0;
    bus.req_vld = 1'b0; bus.req_we = 1'b0; bus.req_f3 = 3'b0;
    bus.req_a = '0; bus.req_wd = '0; bus.mem_rd = '0;
    for (int w = 0; w < 16384; w++) begin
      v = $urandom;
      poke(16'(w * 4), v);
    end

    rstn = 1'b0;
    #1;
    chk("rst_rdy", bus.req_rdy, 1);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rd", bus.rsp_rd, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_wd", bus.mem_wd, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    poke(16'h0010, 32'h8899AABB);
    acc(1'b0, 3'b010, 16'h0010, 32'h0);
    poke(16'h0010, 32'h80FF0000);
    acc(1'b0, 3'b000, 16'h0013, 32'h0);
    acc(1'b0, 3'b100, 16'h0013, 32'h0);
    acc(1'b1, 3'b001, 16'h0022, 32'h00001234);
    acc(1'b0, 3'b101, 16'h0022, 32'h0);
    poke(16'h0004, 32'h44332211);
    poke(16'h0008, 32'h88776655);
    acc(1'b0, 3'b010, 16'h0006, 32'h0);
    acc(1'b1, 3'b010, 16'hFFFF, 32'hDDCCBBAA);
    acc(1'b0, 3'b010, 16'hFFFF, 32'h0);
    acc(1'b0, 3'b011, 16'h0040, 32'h0);
    acc(1'b1, 3'b111, 16'h0040, 32'h11223344);

    // Reset during beat 2 of a split load.
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_we = 1'b0; bus.req_f3 = 3'b010; bus.req_a = 16'h0006;
    @(negedge clk); #1;
    chk("rst_split_rdy_pre", bus.req_rdy, 0);
    rstn = 1'b0;
    #1;
    chk("rst_split_rdy", bus.req_rdy, 1);
    chk("rst_split_mem_a", bus.mem_a, 0);
    chk("rst_split_mem_re", bus.mem_re, 0);
    chk("rst_split_mem_we", bus.mem_we, 0);
    chk("rst_split_mem_wd", bus.mem_wd, 0);
    chk("rst_split_rsp_vld", bus.rsp_vld, 0);
    @(negedge clk);
    bus.req_vld = 1'b0;
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("rst_split_no_rsp", bus.rsp_vld, 0);
    chk("rst_split_no_err", bus.rsp_err, 0);

    // Back-to-back aligned loads.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        a = 16'h0100 + 16'(4 * i);
        bus.req_vld = 1'b1; bus.req_we = 1'b0; bus.req_f3 = 3'b010; bus.req_a = a;
        q.push_back(ref_load(3'b010, a));
      end else begin
        bus.req_vld = 1'b0;
      end
      #1;
      if (i < 8) chk("b2b_rdy", bus.req_rdy, 1);
      if (i > 0) begin
        chk("b2b_rsp_vld", bus.rsp_vld, 1);
        chk("b2b_rsp_rd", bus.rsp_rd, q.pop_front());
      end
    end
    @(negedge clk); #1;
    chk("b2b_tail", bus.rsp_vld, 0);

    // Randomized mix against the byte-level reference model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'hFFFC + 16'($urandom_range(0, 3));
      else                           a = 16'h0200 + 16'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      if (we && (f3 == 3'b100 || f3 == 3'b101)) f3 = {1'b0, f3[1:0]};
      acc(we, f3, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
